// File: rtl/func_chk_pkg.sv
// -----------------------------------------------------------------------------
// func_chk_pkg
//   Shared definitions for the function sweep checker:
//     state_t      - sweep controller states (IDLE, RUN, DONE)
//     lut_bits(n)  - number of truth-table entries for an n-input function
//     DEFAULT_LUT  - a&c | b&~c&d | a&~b&~c as a 4-input truth table
// -----------------------------------------------------------------------------
package func_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_LUT = 16'hAEA2;

    function automatic int lut_bits(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   One switch bit: two-flop synchroniser followed by an optional stability
//   filter. With FUNC_CHK_DEBOUNCE_EN defined, a new level is accepted only
//   after the synchronised bit has differed from the accepted level for
//   DB_CYCLES consecutive cycles; any return to the accepted level restarts
//   the count. Without the macro, db_out is the synchroniser output.
//
//   Ports:
//     clk     in   system clock
//     rst_n   in   asynchronous active-low reset
//     raw     in   asynchronous switch level
//     db_out  out  synchronised (and, if enabled, debounced) level
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db_out
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef FUNC_CHK_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // For a single bit, "sync differs from accepted level" restarting on every
    // return to the accepted level is the same as restarting on any change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync2_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign db_out = db_q;
`else
    // DB_CYCLES has no effect in this build; the guard keeps the parameter
    // list identical between builds.
    if (DB_CYCLES >= 0) begin : g_raw
        assign db_out = sync2_q;
    end
`endif

endmodule

// File: rtl/func_sweep_checker.sv
// -----------------------------------------------------------------------------
// func_sweep_checker
//   Compares two N_IN-input Boolean functions given as truth tables.
//   Manual mode (mode=0): vec follows the filtered switches and the LEDs show
//   f_A(vec), f_B(vec) and their difference. Sweep mode (mode=1, start pulse):
//   every vector 0..2^N_IN-1 is held for DWELL cycles; mismatches are counted
//   and the lowest failing vector is recorded.
//   Build option: FUNC_CHK_DEBOUNCE_EN enables the switch debounce filter.
//
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     switches[N_IN]   raw board switches
//     mode             0 = manual, 1 = sweep
//     start            single-cycle sweep start pulse
//     led_a/led_b      registered f_A(vec) / f_B(vec)
//     led_diff         registered led_a ^ led_b
//     vec[N_IN]        vector currently evaluated
//     busy / done      sweep running / sweep completed
//     mismatch_cnt     differing vectors in the last sweep (N_IN+1 bits)
//     first_bad        lowest differing vector, valid with first_bad_vld
//   The controller state is available as state_q for assertion binding.
// -----------------------------------------------------------------------------
module func_sweep_checker
    import func_chk_pkg::*;
#(
    parameter int                         N_IN      = 4,
    parameter logic [lut_bits(N_IN)-1:0]  LUT_A     = DEFAULT_LUT,
    parameter logic [lut_bits(N_IN)-1:0]  LUT_B     = DEFAULT_LUT,
    parameter int                         DB_CYCLES = 16,
    parameter int                         DWELL     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] switches,
    input  logic            mode,
    input  logic            start,
    output logic            led_a,
    output logic            led_b,
    output logic            led_diff,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_bad,
    output logic            first_bad_vld
);

    localparam int              DW_W     = $clog2(DWELL + 1);
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   db_vec;
    logic [N_IN-1:0]   sweep_vec_q;
    logic [DW_W-1:0]   dwell_q;
    logic [N_IN:0]     cnt_q;
    logic [N_IN-1:0]   first_bad_q;
    logic              first_bad_vld_q;
    logic              led_a_q, led_b_q, led_diff_q;
    logic              last_dwell;
    logic              enter_run;
    logic              step;
    logic              vec_differs;

    // ---------------------------------------------------------------- inputs
    for (genvar i = 0; i < N_IN; i++) begin : g_sw
        sw_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_sw_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (switches[i]),
            .db_out (db_vec[i])
        );
    end

    // ------------------------------------------------------------ controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dwell = (dwell_q == DW_W'(DWELL - 1));
        case (state_q)
            IDLE: if (mode && start) state_d = RUN;
            RUN: begin
                if (!mode) begin
                    state_d = IDLE;
                end else if (last_dwell && (sweep_vec_q == LAST_VEC)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mode) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        enter_run   = (state_q != RUN) && (state_d == RUN);
        // A vector is judged only if the sweep is not being aborted this cycle.
        step        = (state_q == RUN) && mode && last_dwell;
        vec_differs = LUT_A[sweep_vec_q] ^ LUT_B[sweep_vec_q];
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_vec_q     <= '0;
            dwell_q         <= '0;
            cnt_q           <= '0;
            first_bad_q     <= '0;
            first_bad_vld_q <= 1'b0;
        end else if (enter_run) begin
            sweep_vec_q     <= '0;
            dwell_q         <= '0;
            cnt_q           <= '0;
            first_bad_q     <= '0;
            first_bad_vld_q <= 1'b0;
        end else if ((state_q == RUN) && mode) begin
            if (step) begin
                dwell_q <= '0;
                if (vec_differs) begin
                    cnt_q <= cnt_q + (N_IN + 1)'(1);
                    if (!first_bad_vld_q) begin
                        first_bad_q     <= sweep_vec_q;
                        first_bad_vld_q <= 1'b1;
                    end
                end
                // The final vector stays put so DONE reports it.
                if (sweep_vec_q != LAST_VEC) begin
                    sweep_vec_q <= sweep_vec_q + N_IN'(1);
                end
            end else begin
                dwell_q <= dwell_q + DW_W'(1);
            end
        end
    end

    // In IDLE the filtered switches are already registered, so vec needs no
    // extra stage; elsewhere the sweep counter is shown.
    assign vec = (state_q == IDLE) ? db_vec : sweep_vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_a_q    <= 1'b0;
            led_b_q    <= 1'b0;
            led_diff_q <= 1'b0;
        end else begin
            led_a_q    <= LUT_A[vec];
            led_b_q    <= LUT_B[vec];
            led_diff_q <= LUT_A[vec] ^ LUT_B[vec];
        end
    end

    // ---------------------------------------------------------------- outputs
    assign led_a         = led_a_q;
    assign led_b         = led_b_q;
    assign led_diff      = led_diff_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign mismatch_cnt  = cnt_q;
    assign first_bad     = first_bad_q;
    assign first_bad_vld = first_bad_vld_q;

endmodule

// File: doc/func_sweep_checker.md
# func_sweep_checker

Parametrised checker comparing two N-input Boolean functions, each given as a truth-table parameter. Used on the EGO1 board to show that a hazard-free (consensus-term) implementation is logically equal to the minimal one. Manual mode: evaluates both functions on debounced switch inputs and drives LEDs. Sweep mode: steps through all 2^N input vectors, counts mismatches and records the first failing vector.

## Interface
Parameters:
- N_IN, 4: number of function inputs (2..8). Bit 0 of the input vector is variable a.
- LUT_A, 16'hAEA2: truth table of function A, width 2^N_IN. Bit i is f({d,c,b,a}=i). The default is a&c | b&~c&d | a&~b&~c.
- LUT_B, 16'hAEA2: truth table of function B. The default is the consensus-extended form of A.
- DB_CYCLES, 16: number of cycles a synchronised switch must stay stable before it is accepted (≥2).
- DWELL, 4: number of cycles each vector is held in sweep (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- switches  in  N_IN  raw board switches (asynchronous)
- mode  in  1  0 = manual, 1 = sweep
- start  in  1  single-cycle pulse that starts a sweep
- led_a  out  1  registered f_A(current vector)
- led_b  out  1  registered f_B(current vector)
- led_diff  out  1  registered led_a ^ led_b
- vec  out  N_IN  current evaluated vector
- busy  out  1  high while the sweep is running
- done  out  1  high after a sweep completes
- mismatch_cnt  out  N_IN+1  number of differing vectors in the last sweep
- first_bad  out  N_IN  lowest vector at which A≠B
- first_bad_vld  out  1  high when first_bad is valid

## Operation
- Reset: every output is 0, the state is IDLE, and the debounce counters and synchronisers are 0.
- States:
  - IDLE: when mode=0, vec follows the debounced switch vector.
  - IDLE → RUN: when mode=1 and start=1.
  - RUN → DONE: after the last vector's dwell completes.
  - DONE → RUN: when start=1 and mode=1.
  - Any state → IDLE: when mode=0.
- Entering RUN:
  - mismatch_cnt, first_bad and first_bad_vld are cleared.
  - vec is set to 0 and the dwell counter to 0.
  - busy is set to 1 and done to 0.
- In RUN, each vector is held for DWELL cycles. On the last dwell cycle:
  - LUT_A[vec] and LUT_B[vec] are compared combinationally.
  - On a mismatch, mismatch_cnt is incremented. If first_bad_vld=0, first_bad is set to vec and first_bad_vld to 1.
  - vec then increments. At vec = 2^N_IN−1, the state moves to DONE instead; vec does not wrap.
- DONE: busy=0, done=1, and vec holds 2^N_IN−1. Results are held until the next start or until mode falls.
- mode falling during RUN: the sweep aborts to IDLE, busy clears, done stays 0, and results hold their partial values.
- start while busy is ignored. start with mode=0 is ignored.
- led_a, led_b and led_diff are registered from vec every cycle in every state.
- mismatch_cnt is N_IN+1 bits wide, so it never overflows; its maximum value is 2^N_IN.

## Timing
- Synchroniser: 2 flops per switch bit.
- Debounce: the per-bit counter restarts on any change of the synchronised bit. The bit is accepted when it has been stable for DB_CYCLES cycles.
- Manual latency (raw switch edge held stable):
  - vec updates DB_CYCLES+2 cycles after the edge.
  - led_* update 1 cycle after vec.
- Sweep:
  - start at cycle t gives busy=1 and vec=0 at t+1.
  - The sweep occupies exactly 2^N_IN·DWELL cycles in RUN.
  - done rises at t+1+2^N_IN·DWELL.
- Counter and first_bad updates are visible the cycle after the compare cycle.
- Reset asserted mid-sweep immediately returns all outputs to their reset values.

## Configuration
- FUNC_CHK_DEBOUNCE_EN
  - Defined: each bit passes through the synchroniser and the DB_CYCLES debounce filter.
  - Undefined: the debounce is removed; vec follows the synchroniser output. Manual latency becomes 2 cycles to vec and 3 cycles to led_*.
  - Sweep behaviour is identical either way.

## Structure
- Package func_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function lut_bits(n) = 2**n;
  - the localparam default LUT constant 16'hAEA2.
- Sub-module sw_debounce: one instance per switch bit, containing the synchroniser and the debounce counter. Its debounce logic sits under the macro.

## Test plan
- Reset, then mode=0 with switches=4'b0001 held → vec=1, led_a=led_b=1, led_diff=0 at DB_CYCLES+3 cycles.
- Switch bit 2 bounces every 5 cycles for 40 cycles, then settles at 1 → vec does not change until DB_CYCLES stable cycles after the last bounce.
- Defaults, mode=1, start pulse → busy for 64 cycles, then done=1, mismatch_cnt=0, first_bad_vld=0.
- LUT_B=16'hAEA0 (vector 1 differs) plus 16'h0800 flip (vector 11) → mismatch_cnt=2, first_bad=1, first_bad_vld=1.
- mode dropped after 20 cycles of RUN → IDLE, busy=0, done=0, partial mismatch_cnt held. A second start with mode=1 clears the results and reruns.
- start pulsed during RUN → ignored; total run length stays 2^N_IN·DWELL cycles.
